// File: rtl/note_scheduler.sv
// Note sequencer: queues note bytes from the UART receiver and plays them on the buzzer.
// Define NOTE_SCHED_LOOP_EN to add queue replay (loop_mode toggled by byte 8'hFE).
module note_scheduler #(
    parameter logic [31:0] BEAT_CNT_MAX = 32'd31_249_999,
    parameter logic [23:0] GAP_CNT_MAX  = 24'd6_249_999,
    parameter int          FIFO_AW      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_flag,
    input  logic [7:0] op_data,
    output logic [2:0] note_sel,
    output logic       tone_en,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);
    localparam int               DEPTH    = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    state_t             state;
    logic [5:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [31:0]        beat_cnt;
    logic [23:0]        gap_cnt;
    logic [2:0]         dur_cnt;
    logic [2:0]         cur_dur;

    logic       is_note;
    logic       is_stop;
    logic       loop_on;
    logic       pop;
    logic       recycle;
    logic       push_note;
    logic       wr_en;
    logic [5:0] head;
    logic [5:0] wr_data;

    assign is_note = op_flag && !op_data[7];
    assign is_stop = op_flag && (op_data == 8'hFF);
    assign head    = mem[rd_ptr];

`ifdef NOTE_SCHED_LOOP_EN
    logic loop_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            loop_mode <= 1'b0;
        else if (is_stop)
            loop_mode <= 1'b0;
        else if (op_flag && (op_data == 8'hFE))
            loop_mode <= !loop_mode;
    end

    assign loop_on = loop_mode;
`else
    assign loop_on = 1'b0;
`endif

    // STOP suppresses the pop so a flush can never race a LOAD.
    assign pop       = (state == LOAD) && !is_stop;
    assign recycle   = pop && loop_on;
    assign push_note = is_note && !loop_on && ((count != FULL_CNT) || pop);
    assign wr_en     = push_note || recycle;
    assign wr_data   = recycle ? head : op_data[5:0];

    assign busy      = (state != IDLE) || (count != '0);
    assign fifo_full = (count == FULL_CNT);

    // NOTE: the storage array has no reset; count and pointers alone define valid entries.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (is_stop) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            count    <= count + {{FIFO_AW{1'b0}}, wr_en} - {{FIFO_AW{1'b0}}, pop};
            overflow <= is_note && !push_note;
        end
    end

    // NOTE: non-blocking assignments throughout, so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            note_sel <= 3'd0;
            tone_en  <= 1'b0;
            beat_cnt <= '0;
            gap_cnt  <= '0;
            dur_cnt  <= '0;
            cur_dur  <= '0;
        end else if (is_stop) begin
            state    <= IDLE;
            note_sel <= 3'd0;
            tone_en  <= 1'b0;
            beat_cnt <= '0;
            gap_cnt  <= '0;
            dur_cnt  <= '0;
            cur_dur  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0)
                        state <= LOAD;
                end
                LOAD: begin
                    note_sel <= head[2:0];
                    tone_en  <= (head[2:0] != 3'd0);
                    cur_dur  <= head[5:3];
                    beat_cnt <= '0;
                    dur_cnt  <= '0;
                    state    <= PLAY;
                end
                PLAY: begin
                    if (beat_cnt == BEAT_CNT_MAX) begin
                        beat_cnt <= '0;
                        if (dur_cnt == cur_dur) begin
                            tone_en <= 1'b0;
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            dur_cnt <= dur_cnt + 3'd1;
                        end
                    end else begin
                        beat_cnt <= beat_cnt + 32'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_CNT_MAX) begin
                        gap_cnt  <= '0;
                        note_sel <= 3'd0;
                        state    <= (count != '0) ? LOAD : IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 24'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_note_scheduler.sv
// Self-checking bench for note_scheduler: directed scenarios plus random bytes vs a queue model.
// Build with +define+NOTE_SCHED_LOOP_EN to also cover the loop_mode feature.
module tb_note_scheduler;
    localparam int BEAT   = 9;
    localparam int GAP_C  = 3;
    localparam int DEPTH  = 8;
    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_PLAY = 2;
    localparam int P_GAP  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_flag;
    logic [7:0] op_data;
    logic [2:0] note_sel;
    logic       tone_en;
    logic       busy;
    logic       fifo_full;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    // Behavioural model: a queue of stored entries and a countdown of remaining phase cycles.
    logic [5:0] mq[$];
    int         m_phase;
    int         m_left;
    logic [2:0] m_note;
    logic       m_tone;
    logic       m_ovf;
    logic       m_loop;

    logic [2:0] starts[$];
    logic [2:0] prev_sel = 3'd0;
    int         n;
    int         first;
    int         novf;
    int         r;

    always #5 clk = ~clk;

    note_scheduler #(
        .BEAT_CNT_MAX(32'd9),
        .GAP_CNT_MAX (24'd3),
        .FIFO_AW     (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .op_flag  (op_flag),
        .op_data  (op_data),
        .note_sel (note_sel),
        .tone_en  (tone_en),
        .busy     (busy),
        .fifo_full(fifo_full),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_phase = P_IDLE;
        m_left  = 0;
        m_note  = 3'd0;
        m_tone  = 1'b0;
        m_ovf   = 1'b0;
        m_loop  = 1'b0;
    endtask

    task automatic model_step(input logic f, input logic [7:0] d);
        int         cnt;
        logic       popped;
        logic [5:0] h;
        cnt    = mq.size();
        popped = 1'b0;
        if (f && d == 8'hFF) begin
            model_reset();
            return;
        end
        case (m_phase)
            P_IDLE: if (cnt > 0) m_phase = P_LOAD;
            P_LOAD: begin
                h       = mq.pop_front();
                popped  = 1'b1;
                m_note  = h[2:0];
                m_tone  = (h[2:0] != 3'd0);
                m_left  = (int'(h[5:3]) + 1) * (BEAT + 1);
                m_phase = P_PLAY;
                if (m_loop) mq.push_back(h);
            end
            P_PLAY: begin
                m_left--;
                if (m_left == 0) begin
                    m_tone  = 1'b0;
                    m_left  = GAP_C + 1;
                    m_phase = P_GAP;
                end
            end
            P_GAP: begin
                m_left--;
                if (m_left == 0) begin
                    m_note  = 3'd0;
                    m_phase = (cnt > 0) ? P_LOAD : P_IDLE;
                end
            end
            default: m_phase = P_IDLE;
        endcase
        m_ovf = 1'b0;
        if (f && !d[7]) begin
            if (!m_loop && (cnt < DEPTH || popped)) mq.push_back(d[5:0]);
            else m_ovf = 1'b1;
        end
`ifdef NOTE_SCHED_LOOP_EN
        if (f && d == 8'hFE) m_loop = !m_loop;
`endif
    endtask

    function automatic logic [6:0] exp_outs();
        logic be;
        logic fe;
        be = (m_phase != P_IDLE) || (mq.size() != 0);
        fe = (mq.size() == DEPTH);
        return {m_note, m_tone, be, fe, m_ovf};
    endfunction

    // One clock: present a byte, advance the model on the edge, compare all outputs 1 ns later.
    task automatic step(input logic f, input logic [7:0] d);
        op_flag = f;
        op_data = d;
        @(posedge clk);
        model_step(f, d);
        #1;
        check("outs", 32'({note_sel, tone_en, busy, fifo_full, overflow}), 32'(exp_outs()));
        if (note_sel != 3'd0 && prev_sel == 3'd0) starts.push_back(note_sel);
        prev_sel = note_sel;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "simulation timeout");
    end

    initial begin
        rst     = 1'b1;
        op_flag = 1'b0;
        op_data = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", 32'({note_sel, tone_en, busy, fifo_full, overflow}), 32'd0);
        rst = 1'b0;

        // Single Do, dur 0: tone two edges after sampling, 10 cycles long, 4 gap cycles, idle.
        step(1'b1, 8'h01);
        first = -1;
        n     = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 8'h00);
            if (tone_en && note_sel == 3'd1) begin
                n++;
                if (first < 0) first = k;
            end
            if (k == 16) check("s1_idle_busy", 32'(busy), 32'd0);
        end
        check("s1_first_tone", 32'(first), 32'd2);
        check("s1_tone_len", 32'(n), 32'd10);

        // Mi dur 2 followed by a rest.
        step(1'b1, 8'h13);
        step(1'b1, 8'h00);
        n = 0;
        for (int k = 2; k <= 55; k++) begin
            step(1'b0, 8'h00);
            if (tone_en) n++;
            if (k == 50) check("s2_gap_busy", 32'(busy), 32'd1);
            if (k == 51) check("s2_idle_busy", 32'(busy), 32'd0);
        end
        check("s2_tone_len", 32'(n), 32'd30);

        // Asynchronous reset in the middle of PLAY.
        step(1'b1, 8'h11);
        for (int k = 0; k < 8; k++) step(1'b0, 8'h00);
        check("pre_reset_tone", 32'(tone_en), 32'd1);
        #2 rst = 1'b1;
        #1 check("async_reset_outs", 32'({note_sel, tone_en, busy, fifo_full, overflow}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Ten notes during a long note: 8 stored, 2 dropped, played in order.
        starts.delete();
        novf = 0;
        step(1'b1, 8'h3D);
        repeat (3) step(1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(i % 7 + 1));
            if (overflow) novf++;
            if (i == 6) check("s3_not_full_7", 32'(fifo_full), 32'd0);
            if (i == 7) check("s3_full_8", 32'(fifo_full), 32'd1);
        end
        for (int k = 0; k < 260; k++) begin
            step(1'b0, 8'h00);
            if (overflow) novf++;
        end
        check("s3_overflow_pulses", 32'(novf), 32'd2);
        check("s3_nplayed", 32'(starts.size()), 32'd9);
        for (int i = 0; i < 9 && i < starts.size(); i++)
            check("s3_order", 32'(starts[i]), (i == 0) ? 32'd5 : 32'((i - 1) % 7 + 1));

        // STOP mid-PLAY with three queued notes, then normal replay.
        step(1'b1, 8'h3D);
        repeat (3) step(1'b0, 8'h00);
        step(1'b1, 8'h01);
        step(1'b1, 8'h02);
        step(1'b1, 8'h03);
        step(1'b0, 8'h00);
        check("s4_pre_stop_tone", 32'(tone_en), 32'd1);
        step(1'b1, 8'hFF);
        check("s4_stop_tone", 32'(tone_en), 32'd0);
        check("s4_stop_sel", 32'(note_sel), 32'd0);
        check("s4_stop_busy", 32'(busy), 32'd0);
        check("s4_stop_full", 32'(fifo_full), 32'd0);
        check("s4_stop_ovf", 32'(overflow), 32'd0);
        step(1'b1, 8'h02);
        n = 0;
        for (int k = 0; k < 25; k++) begin
            step(1'b0, 8'h00);
            if (tone_en && note_sel == 3'd2) n++;
        end
        check("s4_replay_len", 32'(n), 32'd10);
        check("s4_end_busy", 32'(busy), 32'd0);

        // Full FIFO and a note byte arriving in the LOAD cycle.
        step(1'b1, 8'h01);
        repeat (3) step(1'b0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(2 + i % 6));
        check("s5_full", 32'(fifo_full), 32'd1);
        for (int k = 0; k < 100 && m_phase != P_LOAD; k++) step(1'b0, 8'h00);
        step(1'b1, 8'h06);
        check("s5_load_push_ovf", 32'(overflow), 32'd0);
        check("s5_load_push_full", 32'(fifo_full), 32'd1);
        step(1'b1, 8'hFF);
        step(1'b0, 8'h00);

`ifdef NOTE_SCHED_LOOP_EN
        // Loop mode: queue 1,2 behind a long rest, enable looping, expect 1,2,1,2,...
        starts.delete();
        step(1'b1, 8'h38);
        repeat (3) step(1'b0, 8'h00);
        step(1'b1, 8'h01);
        step(1'b1, 8'h02);
        step(1'b1, 8'hFE);
        for (int k = 0; k < 200; k++) step(1'b0, 8'h00);
        check("s6_nplayed_min", 32'(starts.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < starts.size(); i++)
            check("s6_loop_order", 32'(starts[i]), 32'(i % 2 + 1));
        step(1'b1, 8'h03);
        check("s6_loop_ovf", 32'(overflow), 32'd1);
        step(1'b1, 8'hFF);
        check("s6_stop_busy", 32'(busy), 32'd0);
        step(1'b1, 8'h01);
        for (int k = 0; k < 30; k++) step(1'b0, 8'h00);
        check("s6_no_replay", 32'(busy), 32'd0);
`endif

        // Random byte stream: idle cycles, notes, command bytes and occasional STOP.
        step(1'b1, 8'hFF);
        for (int k = 0; k < 2500; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 45)
                step(1'b0, 8'($urandom));
            else if (r < 85)
                step(1'b1, {1'b0, 1'($urandom), 2'b00, 1'($urandom), 3'($urandom)});
            else if (r < 97)
                step(1'b1, 8'($urandom_range(128, 254)));
            else
                step(1'b1, 8'hFF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
